mux8to1_tdm: RTL and testbench
==============================

MUX8TO1_TDM -- requirements
Module: mux8to1_tdm

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with all state updated on the rising edge of clk.
REQ-002 Parameter MSB_FIRST, default 0: 0 transmits bit 0 first (sel counts 0..7); 1 transmits bit 7 first (sel counts 7..0).
REQ-003 Port clk, input, 1 bit: the single clock.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port load, input, 1 bit: request to capture data_in and start a frame.
REQ-006 Port data_in, input, 8 bits: parallel word, one bit per channel.
REQ-007 Port tick, input, 1 bit: slot-advance enable, sampled on each clock edge.
REQ-008 Port out, output, 1 bit: serial channel bit, equal to shadow[sel].
REQ-009 Port sel, output, 3 bits: index of the channel currently on out.
REQ-010 Port valid, output, 1 bit: out and sel are meaningful; equals busy.
REQ-011 Port busy, output, 1 bit: a frame is in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse after the last slot completes.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE and SEND.
REQ-014 IDLE behaviour: busy=0, valid=0, out=0, sel=first index (0, or 7 if MSB_FIRST=1).
REQ-015 IDLE with load=1 at a clock edge: the block SHALL capture data_in into an 8-bit shadow register, enter SEND, and set sel to the first index.
REQ-016 Latency: the first bit SHALL appear on out, with valid=1, in the cycle after the capturing edge.
REQ-017 SEND with tick=1 at an edge, when sel is not the last index: sel SHALL advance by one (incrementing if MSB_FIRST=0, decrementing if MSB_FIRST=1).
REQ-018 SEND with tick=0 at an edge: sel, out and the shadow register SHALL hold.
REQ-019 SEND with tick=1 at an edge, when sel is the last index: the block SHALL return to IDLE and pulse done=1 for exactly the following cycle.
REQ-020 Each frame SHALL present exactly 8 slots; the channel on each slot is shadow[sel].
REQ-021 A tick accompanying an accepted load SHALL be ignored, so slot 0 lasts at least until the next tick.
REQ-022 load while busy=1 SHALL be ignored, with no change to shadow or sel.
REQ-023 Changes on data_in while busy=1 SHALL have no effect on out.
REQ-024 tick in IDLE SHALL have no effect.
REQ-025 Back-to-back frames: a load in the cycle where done=1 SHALL be accepted (state is IDLE), giving a minimum of one non-valid cycle between frames.
REQ-026 sel SHALL never wrap from the last index back to the first index while in SEND.

Reset
REQ-027 rst=1 at an edge SHALL force: IDLE, shadow=0, sel=first index, out=0, valid=0, busy=0, done=0.
REQ-028 rst SHALL take priority over load and tick, and SHALL abort a frame mid-operation without asserting done.

Structure
REQ-029 State encoding (IDLE, SEND), WIDTH=8 and SEL_W=3 SHALL reside in the shared package mux8_tdm_pkg.
REQ-030 The slot counter SHALL be the sub-module sel_counter: 3-bit, with enable, direction and synchronous clear.
REQ-031 out SHALL be driven by a combinational 8-to-1 selection of shadow by sel, gated to 0 when not valid.

Verification
REQ-032 Scenario: rst=1 for 2 cycles with random inputs -> out=0, sel=0, valid=0, busy=0, done=0.
REQ-033 Scenario: MSB_FIRST=0, load with data_in=8'hA5, then tick=1 continuously -> sel=0..7 on consecutive cycles, out=1,0,1,0,0,1,0,1, done high one cycle after sel=7.
REQ-034 Scenario: MSB_FIRST=1, data_in=8'h80, tick every 3rd cycle -> sel=7..0, each slot held 3 cycles, out=1 only while sel=7.
REQ-035 Scenario: load with 8'hFF, then load with 8'h00 asserted at slot 3, and data_in changed -> load ignored, remaining out bits all 1.
REQ-036 Scenario: rst asserted at slot 4 -> next cycle IDLE with valid=0 and no done pulse; a subsequent load with 8'h3C transmits correctly.
REQ-037 Scenario: second load asserted in the done cycle -> new frame starts; exactly one valid=0 cycle between frames.

Source files
------------

// File: rtl/mux8_tdm_pkg.sv
// Shared constants for the 8-channel TDM serialiser: widths, FSM encoding
// and helpers that map the bit order onto the first and last slot index.
package mux8_tdm_pkg;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  function automatic logic [SEL_W-1:0] first_index(input bit msb_first);
    return msb_first ? SEL_W'(WIDTH - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] last_index(input bit msb_first);
    return msb_first ? '0 : SEL_W'(WIDTH - 1);
  endfunction

endpackage

// File: rtl/sel_counter.sv
// Slot index counter: synchronous clear to a fixed start value, then counts
// up or down by one on each enabled edge.
module sel_counter
  import mux8_tdm_pkg::*;
#(
  parameter logic [SEL_W-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             down,
  output logic [SEL_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= CLEAR_VAL;
    end else if (en) begin
      count <= down ? count - 1'b1 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mux8to1_tdm.sv
// Captures an 8-bit word and serialises it one channel per slot; slots
// advance on tick and done pulses for one cycle after the last slot.
module mux8to1_tdm
  import mux8_tdm_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             tick,
  output logic             out,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W-1:0] FIRST_SEL = first_index(MSB_FIRST);
  localparam logic [SEL_W-1:0] LAST_SEL  = last_index(MSB_FIRST);

  logic [0:0]       state;
  logic [WIDTH-1:0] shadow;
  logic             done_q;
  logic             sending;
  logic             at_last;
  logic             accept;
  logic             slot_adv;
  logic             frame_end;

  assign sending   = (state == ST_SEND);
  assign at_last   = (sel == LAST_SEL);
  assign accept    = !sending && load;
  assign slot_adv  = sending && tick && !at_last;
  assign frame_end = sending && tick && at_last;

  // A tick arriving with the capturing load is ignored because the counter
  // is held in clear for the whole time the FSM sits in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      shadow <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (accept) begin
        state  <= ST_SEND;
        shadow <= data_in;
      end else if (frame_end) begin
        state <= ST_IDLE;
      end
    end
  end

  sel_counter #(
    .CLEAR_VAL(FIRST_SEL)
  ) u_sel_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(!sending || frame_end),
    .en   (slot_adv),
    .down (MSB_FIRST),
    .count(sel)
  );

  always_comb begin
    out = 1'b0;
    if (sending) begin
      out = shadow[sel];
    end
  end

  assign valid = sending;
  assign busy  = sending;
  assign done  = done_q;

endmodule

// File: tb/tb_mux8to1_tdm.sv
// Bench: an LSB-first and an MSB-first instance share all inputs; every
// accepted frame queues its expected slot sequence for both instances.
module tb_mux8to1_tdm;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] data_in;
  logic       tick;

  logic       out0, valid0, busy0, done0;
  logic [2:0] sel0;
  logic       out1, valid1, busy1, done1;
  logic [2:0] sel1;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 0;

  // Entry layout: {sel0, out0, sel1, out1}.
  logic [7:0] exp_q[$];

  mux8to1_tdm #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .tick(tick),
    .out(out0), .sel(sel0), .valid(valid0), .busy(busy0), .done(done0)
  );

  mux8to1_tdm #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .tick(tick),
    .out(out1), .sel(sel1), .valid(valid1), .busy(busy1), .done(done1)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({3'(i), d[i], 3'(7 - i), d[7 - i]});
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    load    = 1'b1;
    data_in = d;
    tick    = 1'b1;
    push_frame(d);
    cycle();
    load = 1'b0;
    tick = 1'b0;
    check("latency_valid", {valid0, valid1}, 2'b11);
    check("latency_sel", {sel0, sel1}, {3'd0, 3'd7});
    check("latency_out", {out0, out1}, {d[0], d[7]});
  endtask

  // Ticks every `period` cycles with random data_in until done; returns in the done cycle.
  task automatic run_ticks(input int period, input int exp_len);
    int cnt;
    bit got;
    cnt = 0;
    got = 0;
    while (!got && cnt < exp_len + 20) begin
      tick    = ((cnt % period) == (period - 1));
      data_in = 8'($urandom_range(0, 255));
      cycle();
      cnt++;
      if (done0) got = 1;
    end
    tick = 1'b0;
    check("frame_len", cnt, exp_len);
    check("done_cycle", {done0, done1, valid0, valid1}, 4'b1100);
  endtask

  // Scoreboard monitor, sampled on the falling edge
  logic       pv = 1'b0;
  logic [2:0] ps = 3'd0;
  logic [7:0] held = 8'd0;
  logic       prst = 1'b0;

  always @(negedge clk) begin
    logic [7:0] obs;
    logic [7:0] e;
    logic       exp_done;
    if (mon_en) begin
      obs = {sel0, out0, sel1, out1};
      if (valid0 && (!pv || sel0 != ps)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_slot", obs, 8'h00);
        end else begin
          e = exp_q.pop_front();
          check("slot", obs, e);
        end
      end else if (valid0) begin
        check("hold", obs, held);
      end
      if (!valid0) begin
        check("idle_outs", {out0, sel0, out1, sel1, valid1, busy0, busy1},
              {1'b0, 3'd0, 1'b0, 3'd7, 3'b000});
      end else begin
        check("busy_valid", {busy0, busy1, valid1}, 3'b111);
      end
      exp_done = pv && !valid0 && !prst;
      check("done", {done0, done1}, {exp_done, exp_done});
      if (exp_done) check("last_sel", {ps, sel1}, {3'd7, 3'd7});
      pv   = valid0;
      ps   = sel0;
      held = obs;
    end
    prst = rst;
  end

  initial begin
    logic [7:0] d;
    int per;
    rst = 1'b1; load = 1'b0; data_in = 8'h00; tick = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      load    = 1'($urandom_range(0, 1));
      tick    = 1'($urandom_range(0, 1));
      data_in = 8'($urandom_range(0, 255));
      cycle();
    end
    load = 1'b0; tick = 1'b0;
    check("rst_out", {out0, out1}, 2'b00);
    check("rst_sel", {sel0, sel1}, {3'd0, 3'd7});
    check("rst_valid_busy", {valid0, busy0, valid1, busy1}, 4'b0000);
    check("rst_done", {done0, done1}, 2'b00);
    rst = 1'b0;
    mon_en = 1'b1;
    cycle();

    // Ticks while idle do nothing
    tick = 1'b1;
    repeat (3) cycle();
    tick = 1'b0;
    check("idle_tick", {valid0, sel0, valid1, sel1}, {1'b0, 3'd0, 1'b0, 3'd7});

    // A5 with continuous tick, then an immediate back-to-back 80 frame
    start_frame(8'hA5);
    run_ticks(1, 8);
    start_frame(8'h80);
    run_ticks(3, 24);

    // FF frame; load of 00 at slot 3 must be ignored
    start_frame(8'hFF);
    tick = 1'b1;
    repeat (3) cycle();
    check("slot3_sel", {sel0, sel1}, {3'd3, 3'd4});
    load = 1'b1; data_in = 8'h00;
    cycle();
    load = 1'b0;
    check("ignored_load", {valid0, out0, out1}, 3'b111);
    run_ticks(1, 4);

    // Abort at slot 4, with load and tick also asserted
    cycle();
    start_frame(8'h5A);
    tick = 1'b1;
    repeat (4) cycle();
    check("slot4_sel", sel0, 3'd4);
    rst = 1'b1; load = 1'b1;
    cycle();
    exp_q.delete();
    check("abort_outs", {valid0, valid1, out0, out1, done0, done1}, 6'b000000);
    check("abort_sel", {sel0, sel1}, {3'd0, 3'd7});
    rst = 1'b0; load = 1'b0; tick = 1'b0;
    cycle();
    check("abort_no_done", {done0, done1, valid0}, 3'b000);
    start_frame(8'h3C);
    run_ticks(2, 16);

    // Random back-to-back frames
    for (int f = 0; f < 6; f++) begin
      d   = 8'($urandom_range(0, 255));
      per = $urandom_range(1, 3);
      start_frame(d);
      run_ticks(per, 8 * per);
    end

    repeat (3) cycle();
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
